if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//   Fetch sequencer for the instruction memory (Insmem). Insmem has a registered read:
//   the instruction for an address is valid one cycle after that address is sampled.
//   This block owns the fetch PC and drives imem_addr, keeping at most one read in flight.
//   It buffers returned words in a DEPTH-entry FIFO of {pc, ins} and hands them to decode
//   over a valid/ready handshake. It also handles redirects (branch/jump/trap): flush,
//   then refetch from the new target.
// PARAMETERS
//   RESET_PC   32'h0000_0000  first fetch address after reset; bits[1:0] must be 0
//   DEPTH      2              FIFO entries; power of 2, >=2
// PORTS
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous, active-low reset
//   imem_addr       out  32  address to Insmem PC input
//   imem_req        out  1   1 = imem_addr is a live fetch this cycle (issue)
//   imem_ins        in   32  Insmem ins output; valid the cycle after issue
//   redirect_valid  in   1   1 = discard all fetched/in-flight words, restart at redirect_pc
//   redirect_pc     in   32  redirect target; bits[1:0] ignored (forced 0)
//   if_valid        out  1   FIFO head valid
//   if_ready        in   1   decode accepts head this cycle
//   if_pc           out  32  PC of head instruction
//   if_ins          out  32  head instruction word
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - fetch_pc=RESET_PC; inflight=0; FIFO empty (count=0, ptrs=0).
//     - Outputs: if_valid=0, if_pc=0, if_ins=0, imem_req=0, imem_addr=RESET_PC.
//   imem_addr = fetch_pc at all times; it holds its value when not issuing.
//   pop = if_valid & if_ready & ~redirect_valid.
//   issue = ~redirect_valid & (count + inflight - pop < DEPTH). imem_req = issue.
//   On issue: fetch_pc <= fetch_pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0);
//     inflight<=1; inflight_pc<=fetch_pc. No issue: inflight<=0.
//   Cycle after issue, unless redirect in that cycle: push {inflight_pc, imem_ins} at edge.
//   FIFO: push and pop in the same cycle are both honoured; count unchanged.
//     The credit rule guarantees no push when full.
//     if_valid = (count!=0); if_pc/if_ins come from registered head entry.
//     if_pc/if_ins hold when not popped; they are don't-care when if_valid=0.
//   Latency: issue in cycle N -> entry pushed at end of N+1 -> if_valid earliest in N+2.
//   After reset release:
//     - cycle 0 issues RESET_PC; if_valid=1 in cycle 2.
//     - With if_ready held high: one instruction per cycle from cycle 2; never a bubble.
//   Redirect in cycle R (highest priority):
//     - No issue; FIFO flushed; any cycle-R imem_ins response is dropped.
//     - pop ignored; fetch_pc <= {redirect_pc[31:2],2'b00}; inflight<=0.
//     - Cycle R+1 issues target; if_valid=1 in R+3 with if_pc=target.
//     - Back-to-back redirects: the last one wins.
//   Backpressure (if_ready=0): FIFO fills to DEPTH, then issue stops. fetch_pc is never
//     skipped or repeated; the PC sequence at if_pc is strictly +4 between redirects.
//   Reset asserted mid-operation clears state immediately; the in-flight word is lost.
// TESTING
//   T1 reset: rst_n low 3 cyc, release, if_ready=1 -> imem_addr 0,4,8,...;
//      if_valid rises cycle 2; if_pc 0,4,8 consecutive; ins matches memory model.
//   T2 stall: if_ready=0 from cycle 2 -> count reaches 2, imem_req=0, imem_addr held;
//      release -> if_pc resumes with no gap/duplicate.
//   T3 redirect: redirect_valid=1, pc=0x40 while FIFO full -> if_valid=0 in R+1, R+2;
//      if_valid=1 in R+3 with if_pc=0x40, then 0x44.
//   T4 redirect with pop and in-flight read in same cycle -> old words never appear;
//      misaligned pc 0x43 -> if_pc=0x40.
//   T5 wrap: redirect to 0xFFFF_FFF8 -> if_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
//   T6 async reset mid-stream (between edges) -> if_valid=0, imem_addr=RESET_PC
//      immediately; refetch after release as T1.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - instruction memory and decode handshake bundle for the fetch sequencer
interface if_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_ins;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_ins;

    modport master (
        output imem_addr, imem_req, if_valid, if_pc, if_ins,
        input  imem_ins, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_addr, imem_req, if_valid, if_pc, if_ins,
        output imem_ins, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch sequencer: one read in flight, {pc,ins} FIFO to decode, redirect flush
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    if_fetch_ctrl_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          head_valid;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW:0]   credit_used;

    // Credit counts the in-flight read as an occupied slot so a returning word always has room.
    always_comb begin
        head_valid  = (count != '0);
        pop         = head_valid & bus.if_ready & ~bus.redirect_valid;
        push        = inflight & ~bus.redirect_valid;
        credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        issue       = rst_n & ~bus.redirect_valid & (credit_used < DEPTH_C);
    end

    assign bus.imem_addr = fetch_pc;
    assign bus.imem_req  = issue;
    assign bus.if_valid  = head_valid;
    assign bus.if_pc     = pc_mem[rd_ptr];
    assign bus.if_ins    = ins_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Any response arriving this cycle belongs to the old stream and is dropped.
            fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                pc_mem[wr_ptr]  <= inflight_pc;
                ins_mem[wr_ptr] <= bus.imem_ins;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard bench for if_fetch_ctrl with a registered-read memory model
module tb_if_fetch_ctrl;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] exp_tail;

    if_fetch_ctrl_if bus();

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]} + 32'h1357_9BDF;
    endfunction

    // Insmem: word for an address is valid the cycle after the address is sampled.
    always @(posedge clk) bus.imem_ins <= ins_of(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        sb.delete();
        exp_tail = pc & 32'hFFFF_FFFC;
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        exp_t e;
        bus.if_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        if (rv) restart_stream(rpc);
        sb.push_back('{exp_tail, ins_of(exp_tail)});
        exp_tail = exp_tail + 32'd4;
        #2;
        if (bus.if_valid && rdy && !rv) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_pc", bus.if_pc, e.pc);
                check("sb_ins", bus.if_ins, e.ins);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        sb.delete();
        #1;
        check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_pc", bus.if_pc, 32'h0);
        check("rst_ins", bus.if_ins, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        restart_stream(32'h0);
    endtask

    task automatic run_from_reset(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            check("t1_addr", bus.imem_addr, 32'(4 * k));
            check("t1_req", {31'd0, bus.imem_req}, 32'd1);
            check("t1_valid", {31'd0, bus.if_valid}, (k >= 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
    endtask

    initial begin
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        #3;

        // T1: reset then free-running fetch
        apply_reset();
        run_from_reset(8);

        // T2: stall with FIFO full, then resume with no gap
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            check("t2_addr", bus.imem_addr, 32'h20);
            check("t2_req", {31'd0, bus.imem_req}, 32'd0);
            check("t2_valid", {31'd0, bus.if_valid}, 32'd1);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h0);
        check("t2_resume_req", {31'd0, bus.imem_req}, 32'd1);
        check("t2_resume_addr", bus.imem_addr, 32'h20);
        next_cycle();
        repeat (5) begin drive(1'b1, 1'b0, 32'h0); next_cycle(); end

        // T3: redirect while FIFO full
        repeat (3) begin drive(1'b0, 1'b0, 32'h0); next_cycle(); end
        drive(1'b0, 1'b1, 32'h40);
        check("t3_r_req", {31'd0, bus.imem_req}, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t3_r1_valid", {31'd0, bus.if_valid}, 32'd0);
        check("t3_r1_req", {31'd0, bus.imem_req}, 32'd1);
        check("t3_r1_addr", bus.imem_addr, 32'h40);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t3_r2_valid", {31'd0, bus.if_valid}, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t3_r3_valid", {31'd0, bus.if_valid}, 32'd1);
        check("t3_r3_pc", bus.if_pc, 32'h40);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t3_r4_pc", bus.if_pc, 32'h44);
        next_cycle();

        // T4: redirect during pop and in-flight read, misaligned target, back-to-back
        repeat (3) begin drive(1'b1, 1'b0, 32'h0); next_cycle(); end
        drive(1'b1, 1'b1, 32'h43);
        next_cycle();
        repeat (2) begin
            drive(1'b1, 1'b0, 32'h0);
            check("t4_gap_valid", {31'd0, bus.if_valid}, 32'd0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h0);
        check("t4_pc", bus.if_pc, 32'h40);
        next_cycle();
        repeat (2) begin drive(1'b1, 1'b0, 32'h0); next_cycle(); end
        drive(1'b1, 1'b1, 32'h100);
        next_cycle();
        drive(1'b1, 1'b1, 32'h200);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t4_b2b_addr", bus.imem_addr, 32'h200);
        check("t4_b2b_req", {31'd0, bus.imem_req}, 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t4_b2b_pc", bus.if_pc, 32'h200);
        next_cycle();
        repeat (3) begin drive(1'b1, 1'b0, 32'h0); next_cycle(); end

        // T5: PC wrap
        drive(1'b1, 1'b1, 32'hFFFF_FFF8);
        next_cycle();
        repeat (2) begin drive(1'b1, 1'b0, 32'h0); next_cycle(); end
        drive(1'b1, 1'b0, 32'h0);
        check("t5_pc0", bus.if_pc, 32'hFFFF_FFF8);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t5_pc1", bus.if_pc, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t5_pc2", bus.if_pc, 32'h0000_0000);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        check("t5_pc3", bus.if_pc, 32'h0000_0004);
        next_cycle();

        // T6: asynchronous reset between edges mid-stream
        repeat (3) begin drive(1'b1, 1'b0, 32'h0); next_cycle(); end
        drive(1'b1, 1'b0, 32'h0);
        #1;
        apply_reset();
        run_from_reset(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
